// File: rtl/glb_banked_pkg.sv
// Shared definitions for the banked global buffer: default parameters, FSM
// encoding and address decode helpers.
package glb_banked_pkg;

  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_DEPTH_WORDS    = 16384;
  localparam int unsigned DEF_NUM_BANKS      = 4;
  localparam int unsigned DEF_NUM_PORTS      = 2;
  localparam int unsigned DEF_ADDR_W         = 16;
  localparam bit          DEF_CLEAR_ON_RST   = 1'b1;
  localparam int unsigned DEF_BYTES_PER_WORD = DEF_DATA_W / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Byte address to word index; byte-offset bits are dropped.
  function automatic logic [31:0] addr_word(input logic [31:0] addr, input int unsigned byte_sh);
    return addr >> byte_sh;
  endfunction

  function automatic logic [31:0] word_bank(input logic [31:0] word, input int unsigned bank_sh);
    return word & ((32'd1 << bank_sh) - 32'd1);
  endfunction

  function automatic logic [31:0] word_row(input logic [31:0] word, input int unsigned bank_sh);
    return word >> bank_sh;
  endfunction

  // (base + off) mod n for base < n and off <= n, without a divider.
  function automatic int unsigned rr_index(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/glb_banked_if.sv
// Request/response bundle for all ports of the banked global buffer.
interface glb_banked_if
  import glb_banked_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W
);
  localparam int unsigned BYTES = DATA_W / 8;

  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS*BYTES-1:0]  req_we;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        rsp_valid;
  logic [NUM_PORTS*DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/glb_bank.sv
// Single-port synchronous RAM bank with byte strobes and a registered read.
module glb_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROWS   = 4096,
  parameter int unsigned ROW_W  = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [ROW_W-1:0]      addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  localparam int unsigned BYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [ROWS];

  // Any strobe set makes the access a write; all-zero strobes read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (|we) begin
        for (int unsigned i = 0; i < BYTES; i++) begin
          if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/glb_banked.sv
// Multi-port word-interleaved global buffer with per-bank round-robin
// arbitration, 1-cycle read latency and an optional post-reset clear.
module glb_banked
  import glb_banked_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned DEPTH_WORDS  = DEF_DEPTH_WORDS,
  parameter int unsigned NUM_BANKS    = DEF_NUM_BANKS,
  parameter int unsigned NUM_PORTS    = DEF_NUM_PORTS,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter bit          CLEAR_ON_RST = DEF_CLEAR_ON_RST
) (
  input  logic            clk,
  input  logic            rst,
  glb_banked_if.slave     bus,
  output logic            init_busy
);
  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned BYTE_SH = $clog2(BYTES);
  localparam int unsigned BANK_SH = $clog2(NUM_BANKS);
  localparam int unsigned BANK_W  = (NUM_BANKS > 1) ? BANK_SH : 1;
  localparam int unsigned ROWS    = DEPTH_WORDS / NUM_BANKS;
  localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;

  logic [BYTES-1:0]   p_we    [NUM_PORTS];
  logic [DATA_W-1:0]  p_wdata [NUM_PORTS];
  logic [BANK_W-1:0]  p_bank  [NUM_PORTS];
  logic [ROW_W-1:0]   p_row   [NUM_PORTS];

  logic [PORT_W-1:0]  ptr_q   [NUM_BANKS];
  logic [NUM_BANKS-1:0] gnt_c;
  logic [PORT_W-1:0]  win_c   [NUM_BANKS];
  logic [NUM_PORTS-1:0] ready_c;

  logic               bank_en_c    [NUM_BANKS];
  logic [BYTES-1:0]   bank_we_c    [NUM_BANKS];
  logic [ROW_W-1:0]   bank_addr_c  [NUM_BANKS];
  logic [DATA_W-1:0]  bank_wdata_c [NUM_BANKS];
  logic [DATA_W-1:0]  bank_rdata   [NUM_BANKS];

  logic [NUM_PORTS-1:0] rsp_valid_q;
  logic [BANK_W-1:0]  rsp_bank_q   [NUM_PORTS];
  logic [DATA_W-1:0]  rdata_hold_q [NUM_PORTS];
  logic [DATA_W-1:0]  rsp_data_c   [NUM_PORTS];

  // Per-port field split and bank/row decode.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      p_we[p]    = bus.req_we[p*BYTES +: BYTES];
      p_wdata[p] = bus.req_wdata[p*DATA_W +: DATA_W];
      p_bank[p]  = BANK_W'(word_bank(addr_word(32'(bus.req_addr[p*ADDR_W +: ADDR_W]), BYTE_SH),
                                     BANK_SH));
      p_row[p]   = ROW_W'(word_row(addr_word(32'(bus.req_addr[p*ADDR_W +: ADDR_W]), BYTE_SH),
                                   BANK_SH));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
      row_q     <= '0;
      init_busy <= CLEAR_ON_RST;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      init_busy <= (state_d == ST_CLEAR);
    end
  end

  // FSM next state: walk every row once in CLEAR, then stay in RUN.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      ST_CLEAR: begin
        if (row_q == ROW_W'(ROWS - 1)) begin
          state_d = ST_RUN;
          row_d   = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      ST_RUN:  ;
      default: state_d = ST_RUN;
    endcase
  end

  // Round-robin winner per bank: first requesting port at or after the pointer.
  always_comb begin
    logic [PORT_W-1:0] cand;
    cand = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      gnt_c[b] = 1'b0;
      win_c[b] = '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        cand = PORT_W'(rr_index(32'(ptr_q[b]), k, NUM_PORTS));
        if ((state_q == ST_RUN) && !gnt_c[b] && bus.req_valid[cand] &&
            (p_bank[cand] == BANK_W'(b))) begin
          gnt_c[b] = 1'b1;
          win_c[b] = cand;
        end
      end
    end
  end

  always_comb begin
    ready_c = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (gnt_c[b]) ready_c[win_c[b]] = 1'b1;
    end
  end

  assign bus.req_ready = ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) ptr_q[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (gnt_c[b]) ptr_q[b] <= PORT_W'(rr_index(32'(win_c[b]), 1, NUM_PORTS));
      end
    end
  end

  // Bank port steering: clear sweep or the arbitration winner.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_en_c[b]    = 1'b0;
      bank_we_c[b]    = '0;
      bank_addr_c[b]  = '0;
      bank_wdata_c[b] = '0;
      if (state_q == ST_CLEAR) begin
        bank_en_c[b]   = 1'b1;
        bank_we_c[b]   = '1;
        bank_addr_c[b] = row_q;
      end else begin
        bank_en_c[b]    = gnt_c[b];
        bank_we_c[b]    = p_we[win_c[b]];
        bank_addr_c[b]  = p_row[win_c[b]];
        bank_wdata_c[b] = p_wdata[win_c[b]];
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    glb_bank #(
      .DATA_W (DATA_W),
      .ROWS   (ROWS),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk   (clk),
      .en    (bank_en_c[b]),
      .we    (bank_we_c[b]),
      .addr  (bank_addr_c[b]),
      .wdata (bank_wdata_c[b]),
      .rdata (bank_rdata[b])
    );
  end

  // Remember which bank serves each accepted read for the return cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        rsp_bank_q[p]   <= '0;
        rdata_hold_q[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        rsp_valid_q[p] <= ready_c[p] & ~(|p_we[p]);
        if (ready_c[p])     rsp_bank_q[p]   <= p_bank[p];
        if (rsp_valid_q[p]) rdata_hold_q[p] <= rsp_data_c[p];
      end
    end
  end

  // Banks share the read register across ports, so idle ports show a held copy.
  always_comb begin
    bus.rsp_rdata = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rsp_data_c[p] = bank_rdata[rsp_bank_q[p]];
      bus.rsp_rdata[p*DATA_W +: DATA_W] = rsp_valid_q[p] ? rsp_data_c[p] : rdata_hold_q[p];
    end
  end

  assign bus.rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_glb_banked.sv
// Bench for glb_banked: directed vector table, reset/clear sequences and
// randomized traffic against a word-array reference model.
module tb_glb_banked;
  import glb_banked_pkg::*;

  localparam int unsigned NP     = 2;
  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 16;
  localparam int unsigned BPW    = DW / 8;
  localparam int unsigned WORDS  = 16384;
  localparam int unsigned NB     = 4;
  localparam int unsigned NCLEAR = WORDS / NB;

  logic clk;
  logic rst;
  logic init_busy;

  glb_banked_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();

  glb_banked #(
    .DATA_W       (DW),
    .DEPTH_WORDS  (WORDS),
    .NUM_BANKS    (NB),
    .NUM_PORTS    (NP),
    .ADDR_W       (AW),
    .CLEAR_ON_RST (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0]  v;
    logic [BPW-1:0] we0, we1;
    logic [AW-1:0]  a0, a1;
    logic [DW-1:0]  d0, d1;
    logic [NP-1:0]  rdy;
    logic [NP-1:0]  rv;
    logic [DW-1:0]  rd0, rd1;
  } vec_t;

  vec_t tbl [14];

  logic [NP-1:0]    s_v;
  logic [BPW-1:0]   s_we [NP];
  logic [AW-1:0]    s_ad [NP];
  logic [DW-1:0]    s_wd [NP];

  logic [DW-1:0]    m_mem [WORDS];
  int unsigned      m_ptr [NB];
  logic [NP-1:0]    m_rv;
  logic [DW-1:0]    m_rd [NP];

  logic [NP-1:0]    obs_ready;
  logic [NP-1:0]    obs_rv;
  logic [NP*DW-1:0] obs_rd;

  int unsigned n_pass;
  int unsigned n_total;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  function automatic int unsigned word_of(input logic [AW-1:0] a);
    return int'(a) / BPW;
  endfunction

  task automatic model_reset();
    for (int unsigned w = 0; w < WORDS; w++) m_mem[w] = '0;
    for (int unsigned b = 0; b < NB; b++) m_ptr[b] = 0;
    m_rv = '0;
    for (int unsigned p = 0; p < NP; p++) m_rd[p] = '0;
  endtask

  task automatic drive();
    logic [NP*BPW-1:0] we_v;
    logic [NP*AW-1:0]  ad_v;
    logic [NP*DW-1:0]  wd_v;
    for (int unsigned p = 0; p < NP; p++) begin
      we_v[p*BPW +: BPW] = s_we[p];
      ad_v[p*AW +: AW]   = s_ad[p];
      wd_v[p*DW +: DW]   = s_wd[p];
    end
    bus.req_valid = s_v;
    bus.req_we    = we_v;
    bus.req_addr  = ad_v;
    bus.req_wdata = wd_v;
  endtask

  // One bus cycle, entered and left at posedge+1; ready checked mid-cycle,
  // response checked after the edge.
  task automatic run_cycle();
    logic [NP-1:0]    exp_ready;
    logic [NP*DW-1:0] exp_rd;
    bit               taken;
    int unsigned      p;
    int unsigned      w;
    drive();
    @(negedge clk);
    exp_ready = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      taken = 1'b0;
      for (int unsigned k = 0; k < NP; k++) begin
        p = (m_ptr[b] + k) % NP;
        if (!taken && s_v[p] && (word_of(s_ad[p]) % NB == b)) begin
          taken        = 1'b1;
          exp_ready[p] = 1'b1;
          m_ptr[b]     = (p + 1) % NP;
        end
      end
    end
    check("ready", 64'(bus.req_ready), 64'(exp_ready));
    obs_ready = bus.req_ready;
    m_rv = '0;
    for (int unsigned q = 0; q < NP; q++) begin
      if (exp_ready[q]) begin
        w = word_of(s_ad[q]);
        if (s_we[q] == '0) begin
          m_rv[q] = 1'b1;
          m_rd[q] = m_mem[w];
        end else begin
          for (int unsigned i = 0; i < BPW; i++)
            if (s_we[q][i]) m_mem[w][8*i +: 8] = s_wd[q][8*i +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    for (int unsigned q = 0; q < NP; q++) exp_rd[q*DW +: DW] = m_rd[q];
    check("rsp_valid", 64'(bus.rsp_valid), 64'(m_rv));
    check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
    obs_rv = bus.rsp_valid;
    obs_rd = bus.rsp_rdata;
  endtask

  // Entered at posedge+1 right after rst drops; ends at posedge+1 in RUN.
  task automatic measure_clear(input string name);
    int unsigned cnt;
    int unsigned bad;
    bit          done;
    cnt  = 0;
    bad  = 0;
    done = 1'b0;
    s_v = 2'b11;
    s_we[0] = '0; s_we[1] = '0;
    s_ad[0] = 16'h0010; s_ad[1] = 16'h0014;
    drive();
    while (!done && cnt < NCLEAR + 500) begin
      @(negedge clk);
      if (!init_busy) begin
        done = 1'b1;
        s_v  = '0;
        drive();
      end else begin
        cnt++;
        if (bus.req_ready != '0) bad++;
      end
    end
    check({name, "_busy_cycles"}, 64'(cnt), 64'(NCLEAR));
    check({name, "_ready_in_clear"}, 64'(bad), 64'd0);
    check({name, "_busy_dropped"}, 64'(done), 64'd1);
    if (!done) begin
      s_v = '0;
      drive();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    obs_ready = '0; obs_rv = '0; obs_rd = '0;
    tbl[0]  = '{2'b01, 4'h0, 4'h0, 16'h1234, 16'h0000, 32'h0, 32'h0, 2'b01, 2'b01, 32'h0, 32'h0};
    tbl[1]  = '{2'b01, 4'hF, 4'h0, 16'h0010, 16'h0000, 32'hDEADBEEF, 32'h0, 2'b01, 2'b00, 32'h0, 32'h0};
    tbl[2]  = '{2'b01, 4'h2, 4'h0, 16'h0010, 16'h0000, 32'h00005500, 32'h0, 2'b01, 2'b00, 32'h0, 32'h0};
    tbl[3]  = '{2'b01, 4'h0, 4'h0, 16'h0010, 16'h0000, 32'h0, 32'h0, 2'b01, 2'b01, 32'hDEAD55EF, 32'h0};
    tbl[4]  = '{2'b11, 4'hF, 4'hF, 16'h0000, 16'h0004, 32'h11111111, 32'h22222222, 2'b11, 2'b00,
                32'hDEAD55EF, 32'h0};
    tbl[5]  = '{2'b11, 4'h0, 4'h0, 16'h0000, 16'h0004, 32'h0, 32'h0, 2'b11, 2'b11,
                32'h11111111, 32'h22222222};
    tbl[6]  = '{2'b10, 4'h0, 4'hF, 16'h0000, 16'h0020, 32'h0, 32'hCAFEF00D, 2'b10, 2'b00,
                32'h11111111, 32'h22222222};
    tbl[7]  = '{2'b11, 4'h0, 4'h0, 16'h0020, 16'h0020, 32'h0, 32'h0, 2'b01, 2'b01,
                32'hCAFEF00D, 32'h22222222};
    tbl[8]  = '{2'b11, 4'h0, 4'h0, 16'h0020, 16'h0020, 32'h0, 32'h0, 2'b10, 2'b10,
                32'hCAFEF00D, 32'hCAFEF00D};
    tbl[9]  = '{2'b11, 4'h0, 4'h0, 16'h0020, 16'h0020, 32'h0, 32'h0, 2'b01, 2'b01,
                32'hCAFEF00D, 32'hCAFEF00D};
    tbl[10] = '{2'b11, 4'h0, 4'h0, 16'h0020, 16'h0020, 32'h0, 32'h0, 2'b10, 2'b10,
                32'hCAFEF00D, 32'hCAFEF00D};
    tbl[11] = '{2'b01, 4'hF, 4'h0, 16'h0100, 16'h0000, 32'hA5A5A5A5, 32'h0, 2'b01, 2'b00,
                32'hCAFEF00D, 32'hCAFEF00D};
    tbl[12] = '{2'b10, 4'h0, 4'h0, 16'h0000, 16'h0100, 32'h0, 32'h0, 2'b10, 2'b10,
                32'hCAFEF00D, 32'hA5A5A5A5};
    tbl[13] = '{2'b01, 4'h0, 4'h0, 16'h0013, 16'h0000, 32'h0, 32'h0, 2'b01, 2'b01,
                32'hDEAD55EF, 32'hA5A5A5A5};

    // Power-on reset with a request pending.
    rst = 1'b1;
    s_v = 2'b11;
    s_we[0] = '0; s_we[1] = '0;
    s_ad[0] = 16'h1234; s_ad[1] = 16'h0004;
    s_wd[0] = '0; s_wd[1] = '0;
    drive();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst_init_busy", 64'(init_busy), 64'd1);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    measure_clear("clear0");

    // Directed vectors.
    for (int unsigned i = 0; i < 14; i++) begin
      s_v     = tbl[i].v;
      s_we[0] = tbl[i].we0; s_we[1] = tbl[i].we1;
      s_ad[0] = tbl[i].a0;  s_ad[1] = tbl[i].a1;
      s_wd[0] = tbl[i].d0;  s_wd[1] = tbl[i].d1;
      run_cycle();
      check($sformatf("vec%0d_ready", i), 64'(obs_ready), 64'(tbl[i].rdy));
      check($sformatf("vec%0d_rv", i), 64'(obs_rv), 64'(tbl[i].rv));
      check($sformatf("vec%0d_rd", i), 64'(obs_rd), {tbl[i].rd1, tbl[i].rd0});
    end

    // Read in flight when reset hits: response must vanish at once.
    s_v = 2'b01; s_we[0] = '0; s_ad[0] = 16'h0010;
    run_cycle();
    check("inflight_rv_before_rst", 64'(obs_rv), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midrst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("midrst_init_busy", 64'(init_busy), 64'd1);
    s_v = '0;
    drive();
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("midclear_busy", 64'(init_busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    measure_clear("clear1");

    // Old contents are gone after the restarted clear.
    s_v = 2'b01; s_we[0] = '0; s_ad[0] = 16'h0010;
    run_cycle();
    check("post_clear_rd", 64'(obs_rd[DW-1:0]), 64'd0);

    // Randomized traffic on a few words to force bank conflicts.
    s_v = '0;
    obs_ready = '0;
    for (int unsigned cyc = 0; cyc < 600; cyc++) begin
      for (int unsigned p = 0; p < NP; p++) begin
        if (!(s_v[p] && !obs_ready[p])) begin
          s_v[p]  = ($urandom % 10) < 7;
          s_ad[p] = AW'(($urandom % 24) * BPW + ($urandom % BPW));
          s_we[p] = ($urandom % 2 == 0) ? BPW'($urandom) : '0;
          s_wd[p] = $urandom;
        end
      end
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
